// File: rtl/sparse_bitmap_encoder_pkg.sv
// Shared types and sizing for the sparse bitmap encoder.
//   DEF_*             : default stream geometry (128-bit nz words, 32-bit elements, 32-bit chunks)
//   ELEMS             : lanes per nonzero word at the default geometry
//   META_CHUNK_BYTES  : byte stride between consecutive bitmap chunks
//   enc_state_e       : encoder FSM states
//   enc_param_t       : job parameters captured on start
package sparse_bitmap_encoder_pkg;

   localparam int unsigned DEF_BW              = 128;
   localparam int unsigned DEF_DATA_SIZE       = 32;
   localparam int unsigned DEF_META_CHUNK_SIZE = 32;

   localparam int unsigned ELEMS            = DEF_BW / DEF_DATA_SIZE;
   localparam int unsigned META_CHUNK_BYTES = DEF_META_CHUNK_SIZE / 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } enc_state_e;

   typedef struct packed {
      logic [15:0] rows;
      logic [15:0] row_len;
      logic [31:0] meta_base;
      logic [31:0] nz_base;
   } enc_param_t;

endpackage

// File: rtl/sparse_bitmap_encoder_nz_word_packer.sv
// Packs nonzero elements into BW-wide words and presents them as a valid/ready
// write stream with a running byte address.
//   clear_i               : job start, empties lanes and restarts word_idx
//   base_i                : nonzero region byte base (held stable for the job)
//   push_i / push_data_i  : append one nonzero into the next lane
//   flush_i               : emit a partially filled word (ignored if empty)
//   word_o/strb_o/addr_o  : pending word, byte strobes, byte address
//   word_valid_o/ready_i  : write handshake
//   empty_o               : no lanes filled and nothing pending
module sparse_bitmap_encoder_nz_word_packer
   import sparse_bitmap_encoder_pkg::*;
#(
   parameter int unsigned BW        = DEF_BW,
   parameter int unsigned DATA_SIZE = DEF_DATA_SIZE
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clear_i,
   input  logic [31:0]          base_i,
   input  logic                 push_i,
   input  logic [DATA_SIZE-1:0] push_data_i,
   input  logic                 flush_i,
   output logic [BW-1:0]        word_o,
   output logic [BW/8-1:0]      strb_o,
   output logic [31:0]          addr_o,
   output logic                 word_valid_o,
   input  logic                 word_ready_i,
   output logic                 empty_o
);

   localparam int unsigned N_LANES    = BW / DATA_SIZE;
   localparam int unsigned LANE_BYTES = DATA_SIZE / 8;
   localparam int unsigned LW         = (N_LANES > 1) ? $clog2(N_LANES) : 1;
   localparam int unsigned CW         = $clog2(N_LANES) + 1;

   logic [N_LANES-1:0][DATA_SIZE-1:0] lanes_q;
   logic [CW-1:0]                     cnt_q;
   logic [CW-1:0]                     cnt_inc;
   logic [CW-1:0]                     fill_cnt;
   logic [BW/8-1:0]                   strb_q;
   logic [BW/8-1:0]                   strb_fill;
   logic [31:0]                       word_idx_q;
   logic                              valid_q;

   // Strobe covers every lane that will be filled once this cycle's push lands.
   always_comb begin
      cnt_inc   = cnt_q + CW'(1);
      fill_cnt  = push_i ? cnt_inc : cnt_q;
      strb_fill = '0;
      for (int k = 0; k < int'(N_LANES); k++) begin
         if (CW'(k) < fill_cnt) strb_fill[k*LANE_BYTES +: LANE_BYTES] = '1;
      end
   end

   // The lane buffer doubles as the output word: pushes are stalled upstream
   // while a word is pending, so it cannot change under the handshake.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lanes_q    <= '0;
         cnt_q      <= '0;
         strb_q     <= '0;
         word_idx_q <= '0;
         valid_q    <= 1'b0;
      end else if (clear_i) begin
         lanes_q    <= '0;
         cnt_q      <= '0;
         strb_q     <= '0;
         word_idx_q <= '0;
         valid_q    <= 1'b0;
      end else if (valid_q) begin
         if (word_ready_i) begin
            valid_q    <= 1'b0;
            lanes_q    <= '0;
            cnt_q      <= '0;
            word_idx_q <= word_idx_q + 32'd1;
         end
      end else if (push_i) begin
         lanes_q[cnt_q[LW-1:0]] <= push_data_i;
         cnt_q                  <= cnt_inc;
         if (cnt_inc == CW'(N_LANES)) begin
            valid_q <= 1'b1;
            strb_q  <= strb_fill;
         end
      end else if (flush_i && (cnt_q != '0)) begin
         valid_q <= 1'b1;
         strb_q  <= strb_fill;
      end
   end

   assign word_o       = lanes_q;
   assign strb_o       = strb_q;
   assign addr_o       = base_i + word_idx_q * 32'(BW / 8);
   assign word_valid_o = valid_q;
   assign empty_o      = (cnt_q == '0) && !valid_q;

endmodule

// File: rtl/sparse_bitmap_encoder.sv
// Compresses a row-major dense element stream into per-row bitmap chunks plus
// contiguously packed nonzero words, each on its own addressed write stream.
//   clk_i, rst_i                      : clock, synchronous active-high reset
//   start_i + rows_i/row_len_i/bases  : job launch, parameters captured in IDLE
//   data_i/valid_i/ready_o            : dense element input
//   meta_o/meta_addr_o/meta_valid_o/meta_ready_i : bitmap chunk stream
//   nz_o/nz_strb_o/nz_addr_o/nz_valid_o/nz_ready_i : nonzero word stream
//   nnz_o                             : nonzeros encoded in the current job
//   done_o                            : one-cycle job completion pulse
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | accepting elements, emitting chunks and full words
// DRAIN | last element taken; finish pending writes and flush partial word
// DONE  | done_o pulse, back to IDLE
module sparse_bitmap_encoder
   import sparse_bitmap_encoder_pkg::*;
#(
   parameter int unsigned BW              = DEF_BW,
   parameter int unsigned DATA_SIZE       = DEF_DATA_SIZE,
   parameter int unsigned META_CHUNK_SIZE = DEF_META_CHUNK_SIZE
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       start_i,
   input  logic [15:0]                rows_i,
   input  logic [15:0]                row_len_i,
   input  logic [31:0]                meta_base_i,
   input  logic [31:0]                nz_base_i,
   input  logic [DATA_SIZE-1:0]       data_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   output logic [META_CHUNK_SIZE-1:0] meta_o,
   output logic [31:0]                meta_addr_o,
   output logic                       meta_valid_o,
   input  logic                       meta_ready_i,
   output logic [BW-1:0]              nz_o,
   output logic [BW/8-1:0]            nz_strb_o,
   output logic [31:0]                nz_addr_o,
   output logic                       nz_valid_o,
   input  logic                       nz_ready_i,
   output logic [31:0]                nnz_o,
   output logic                       done_o
);

   localparam int unsigned BIT_W = $clog2(META_CHUNK_SIZE);

   enc_state_e                 state_q, state_d;
   enc_param_t                 par_q;
   logic [15:0]                row_q, col_q;
   logic [META_CHUNK_SIZE-1:0] bitmap_q;
   logic                       meta_valid_q;
   logic [31:0]                chunk_idx_q;
   logic [31:0]                nnz_q;

   logic             start_ok, accept, is_nz, row_end, last_row, chunk_end;
   logic             meta_clear, nz_clear, nz_empty, flush;
   logic [BIT_W-1:0] bit_idx;

   assign start_ok  = (state_q == IDLE) && start_i;
   assign accept    = valid_i && ready_o;
   assign is_nz     = |data_i;
   assign bit_idx   = col_q[BIT_W-1:0];
   assign row_end   = (col_q == par_q.row_len - 16'd1);
   assign last_row  = (row_q == par_q.rows - 16'd1);
   assign chunk_end = (&bit_idx) || row_end;

   // Completion looks through the handshake so DONE lands on the edge that
   // retires the final write.
   assign meta_clear = !meta_valid_q || meta_ready_i;
   assign nz_clear   = nz_valid_o ? nz_ready_i : nz_empty;

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) state_d = ((rows_i == 16'd0) || (row_len_i == 16'd0)) ? DONE : RUN;
         end
         RUN: begin
            if (accept && row_end && last_row) state_d = DRAIN;
         end
         DRAIN: begin
            if (meta_clear && nz_clear) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready_o = (state_q == RUN) && !meta_valid_q && !nz_valid_o;
      done_o  = (state_q == DONE);
      flush   = (state_q == DRAIN);
   end

   // bitmap_q is the outgoing chunk; input stalls while it is pending, and it
   // is zeroed on handshake so each chunk (and each row) starts clean.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         par_q        <= '0;
         row_q        <= '0;
         col_q        <= '0;
         bitmap_q     <= '0;
         meta_valid_q <= 1'b0;
         chunk_idx_q  <= '0;
         nnz_q        <= '0;
      end else if (start_ok) begin
         par_q        <= {rows_i, row_len_i, meta_base_i, nz_base_i};
         row_q        <= '0;
         col_q        <= '0;
         bitmap_q     <= '0;
         meta_valid_q <= 1'b0;
         chunk_idx_q  <= '0;
         nnz_q        <= '0;
      end else begin
         if (meta_valid_q && meta_ready_i) begin
            meta_valid_q <= 1'b0;
            bitmap_q     <= '0;
            chunk_idx_q  <= chunk_idx_q + 32'd1;
         end
         if (accept) begin
            bitmap_q[bit_idx] <= is_nz;
            if (chunk_end) meta_valid_q <= 1'b1;
            if (is_nz)     nnz_q        <= nnz_q + 32'd1;
            if (row_end) begin
               col_q <= '0;
               row_q <= row_q + 16'd1;
            end else begin
               col_q <= col_q + 16'd1;
            end
         end
      end
   end

   sparse_bitmap_encoder_nz_word_packer #(
      .BW        (BW),
      .DATA_SIZE (DATA_SIZE)
   ) u_packer (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .clear_i      (start_ok),
      .base_i       (par_q.nz_base),
      .push_i       (accept && is_nz),
      .push_data_i  (data_i),
      .flush_i      (flush),
      .word_o       (nz_o),
      .strb_o       (nz_strb_o),
      .addr_o       (nz_addr_o),
      .word_valid_o (nz_valid_o),
      .word_ready_i (nz_ready_i),
      .empty_o      (nz_empty)
   );

   assign meta_o       = bitmap_q;
   assign meta_addr_o  = par_q.meta_base + chunk_idx_q * 32'(META_CHUNK_SIZE / 8);
   assign meta_valid_o = meta_valid_q;
   assign nnz_o        = nnz_q;

endmodule

// File: tb/tb_sparse_bitmap_encoder.sv
module tb_sparse_bitmap_encoder;
   import sparse_bitmap_encoder_pkg::*;

   localparam int unsigned WB = ELEMS * DEF_DATA_SIZE / 8;
   localparam int unsigned CB = META_CHUNK_BYTES;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          start_i;
   logic [15:0]   rows_i, row_len_i;
   logic [31:0]   meta_base_i, nz_base_i;
   logic [31:0]   data_i;
   logic          valid_i;
   logic          ready_o;
   logic [31:0]   meta_o, meta_addr_o;
   logic          meta_valid_o, meta_ready_i;
   logic [127:0]  nz_o;
   logic [15:0]   nz_strb_o;
   logic [31:0]   nz_addr_o;
   logic          nz_valid_o, nz_ready_i;
   logic [31:0]   nnz_o;
   logic          done_o;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   sparse_bitmap_encoder dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .rows_i(rows_i),
      .row_len_i(row_len_i), .meta_base_i(meta_base_i), .nz_base_i(nz_base_i),
      .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
      .meta_o(meta_o), .meta_addr_o(meta_addr_o), .meta_valid_o(meta_valid_o),
      .meta_ready_i(meta_ready_i), .nz_o(nz_o), .nz_strb_o(nz_strb_o),
      .nz_addr_o(nz_addr_o), .nz_valid_o(nz_valid_o), .nz_ready_i(nz_ready_i),
      .nnz_o(nnz_o), .done_o(done_o)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic start_job(input logic [15:0] rows, input logic [15:0] len,
                            input logic [31:0] mb, input logic [31:0] nb);
      start_i = 1'b1; rows_i = rows; row_len_i = len; meta_base_i = mb; nz_base_i = nb;
      step();
      start_i = 1'b0;
   endtask

   task automatic send(input logic [31:0] d);
      int t = 0;
      valid_i = 1'b1; data_i = d;
      while (!ready_o && t < 20) begin step(); t++; end
      if (!ready_o) chk("send_ready_timeout", ready_o, 1);
      step();
      valid_i = 1'b0; data_i = '0;
   endtask

   task automatic expect_meta(input string tag, input logic [31:0] exp, input logic [31:0] addr);
      int t = 0;
      while (!meta_valid_o && t < 10) begin step(); t++; end
      chk({tag, "_mvalid"}, meta_valid_o, 1);
      chk({tag, "_meta"}, meta_o, exp);
      chk({tag, "_maddr"}, meta_addr_o, addr);
      meta_ready_i = 1'b1;
      step();
      meta_ready_i = 1'b0;
      chk({tag, "_mclr"}, meta_valid_o, 0);
   endtask

   task automatic expect_nz(input string tag, input logic [127:0] exp, input logic [15:0] strb,
                            input logic [31:0] addr);
      int t = 0;
      while (!nz_valid_o && t < 10) begin step(); t++; end
      chk({tag, "_nvalid"}, nz_valid_o, 1);
      chk({tag, "_nz"}, nz_o, exp);
      chk({tag, "_strb"}, nz_strb_o, strb);
      chk({tag, "_naddr"}, nz_addr_o, addr);
      nz_ready_i = 1'b1;
      step();
      nz_ready_i = 1'b0;
      chk({tag, "_nclr"}, nz_valid_o, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] w;
      logic [31:0]  t2_data [8] = '{32'd0, 32'd5, 32'd0, 32'd0, 32'd7, 32'd9, 32'd0, 32'd3};

      rst_i = 1'b1; start_i = 1'b0; rows_i = '0; row_len_i = '0; meta_base_i = '0;
      nz_base_i = '0; data_i = '0; valid_i = 1'b0; meta_ready_i = 1'b0; nz_ready_i = 1'b0;

      // 1: reset then idle
      step(); step();
      rst_i = 1'b0;
      chk("rst_ready", ready_o, 0);
      chk("rst_mvalid", meta_valid_o, 0);
      chk("rst_nvalid", nz_valid_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_nnz", nnz_o, 0);
      chk("rst_meta", {meta_o, meta_addr_o}, 0);
      chk("rst_nz", {nz_o, nz_strb_o, nz_addr_o}, 0);
      for (int c = 0; c < 5; c++) begin
         step();
         chk("idle_quiet", {ready_o, meta_valid_o, nz_valid_o, done_o}, 0);
      end

      // 2: one row of 8, bitmap 0xB2, one full word
      start_job(16'd1, 16'd8, 32'h1000, 32'h2000);
      chk("t2_ready", ready_o, 1);
      for (int i = 0; i < 8; i++) begin
         send(t2_data[i]);
         if (i == 6) chk("t2_early", {meta_valid_o, nz_valid_o}, 0);
      end
      chk("t2_together", {meta_valid_o, nz_valid_o}, 2'b11);
      chk("t2_stall", ready_o, 0);
      expect_meta("t2", 32'h0000_00B2, 32'h1000);
      expect_nz("t2", {32'd3, 32'd9, 32'd7, 32'd5}, 16'hFFFF, 32'h2000);
      chk("t2_done", done_o, 1);
      chk("t2_nnz", nnz_o, 4);
      step();
      chk("t2_done_pulse", done_o, 0);
      step();
      chk("t2_nnz_hold", nnz_o, 4);

      // 3: one row of 40, all nonzero
      start_job(16'd1, 16'd40, 32'h1100, 32'h2100);
      for (int i = 0; i < 40; i++) begin
         send(32'(i + 1));
         if (i == 31) expect_meta("t3_c0", 32'hFFFF_FFFF, 32'h1100);
         if (i == 39) expect_meta("t3_c1", 32'h0000_00FF, 32'h1100 + CB);
         if ((i % 4) == 3) begin
            for (int l = 0; l < 4; l++) w[l*32 +: 32] = 32'(i - 3 + l + 1);
            expect_nz("t3_w", w, 16'hFFFF, 32'h2100 + 32'((i / 4) * WB));
         end
      end
      chk("t3_done", done_o, 1);
      chk("t3_nnz", nnz_o, 40);
      step();

      // 4: two rows of 3, partial word drained
      start_job(16'd2, 16'd3, 32'h1200, 32'h2200);
      send(32'd1); send(32'd0); send(32'd2);
      expect_meta("t4_c0", 32'h5, 32'h1200);
      send(32'd0); send(32'd0); send(32'd3);
      chk("t4_drain_pre", nz_valid_o, 0);
      step();
      chk("t4_drain_valid", nz_valid_o, 1);
      expect_meta("t4_c1", 32'h4, 32'h1200 + CB);
      expect_nz("t4_w", {32'd0, 32'd3, 32'd2, 32'd1}, 16'h0FFF, 32'h2200);
      chk("t4_done", done_o, 1);
      chk("t4_nnz", nnz_o, 3);
      step();

      // 5: meta backpressure with an independent nz handshake
      start_job(16'd2, 16'd4, 32'h3000, 32'h4000);
      send(32'd1); send(32'd2); send(32'd3); send(32'd4);
      valid_i = 1'b1; data_i = 32'd9;
      for (int c = 0; c < 5; c++) begin
         chk("t5_ready", ready_o, 0);
         chk("t5_mvalid", meta_valid_o, 1);
         chk("t5_meta", meta_o, 32'hF);
         chk("t5_maddr", meta_addr_o, 32'h3000);
         if (c < 2) chk("t5_nz", {nz_o, nz_strb_o, nz_addr_o},
                        {32'd4, 32'd3, 32'd2, 32'd1, 16'hFFFF, 32'h4000});
         nz_ready_i = (c == 1);
         step();
         nz_ready_i = 1'b0;
      end
      chk("t5_nz_indep", nz_valid_o, 0);
      chk("t5_nnz", nnz_o, 4);
      valid_i = 1'b0; data_i = '0;
      expect_meta("t5_c0", 32'hF, 32'h3000);
      send(32'd0); send(32'd0); send(32'd0); send(32'd0);
      expect_meta("t5_c1", 32'h0, 32'h3000 + CB);
      chk("t5_done", done_o, 1);
      chk("t5_nnz_end", nnz_o, 4);
      step();

      // 6a: empty job
      start_job(16'd0, 16'd5, 32'h5000, 32'h6000);
      chk("t6a_done", done_o, 1);
      chk("t6a_valids", {meta_valid_o, nz_valid_o}, 0);
      step();
      chk("t6a_done_pulse", done_o, 0);

      // 6b: reset mid-row with a word pending
      start_job(16'd1, 16'd8, 32'h5000, 32'h6000);
      send(32'd1); send(32'd2); send(32'd3); send(32'd4);
      chk("t6b_pending", nz_valid_o, 1);
      rst_i = 1'b1;
      step();
      chk("t6b_valids", {meta_valid_o, nz_valid_o}, 0);
      chk("t6b_nnz", nnz_o, 0);
      rst_i = 1'b0;
      step();
      chk("t6b_idle", {ready_o, done_o, meta_valid_o, nz_valid_o}, 0);

      // 6c: fresh job restarts at the new bases
      start_job(16'd1, 16'd4, 32'h7000, 32'h8000);
      chk("t6c_nnz0", nnz_o, 0);
      send(32'd0); send(32'd0); send(32'd0); send(32'd6);
      expect_meta("t6c_c0", 32'h8, 32'h7000);
      expect_nz("t6c_w", {96'd0, 32'd6}, 16'h000F, 32'h8000);
      chk("t6c_done", done_o, 1);
      chk("t6c_nnz", nnz_o, 1);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sparse_bitmap_encoder.md
# sparse_bitmap_encoder

Write-side counterpart of the X data scheduler. It consumes a stream of dense matrix elements in row-major order and compresses them into the bitmap-plus-nonzeros format that the Gustavson read path decodes. It emits two write streams, each with its own byte address for the streamer sink: metadata chunks and packed nonzero words. It sits between the output accumulator and the HCI write streamers.

## Interface
- BW, 128: nonzero write word width in bits; ELEMS = BW/DATA_SIZE lanes.
- DATA_SIZE, 32: element width in bits.
- META_CHUNK_SIZE, 32: bitmap chunk width in bits.
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  job start pulse; accepted only in IDLE.
- rows_i  in  16  number of rows; latched on start.
- row_len_i  in  16  elements per row; latched on start.
- meta_base_i  in  32  metadata region byte base address; latched on start.
- nz_base_i  in  32  nonzero region byte base address; latched on start.
- data_i  in  DATA_SIZE  dense input element.
- valid_i  in  1  data_i is valid.
- ready_o  out  1  element accepted when valid_i and ready_o are both high.
- meta_o  out  META_CHUNK_SIZE  bitmap chunk; bit k = column (chunk_base+k).
- meta_addr_o  out  32  byte address of the chunk.
- meta_valid_o  out  1  chunk pending.
- meta_ready_i  in  1  chunk consumed.
- nz_o  out  BW  packed nonzeros; lane k = nz_o[k*DATA_SIZE +: DATA_SIZE].
- nz_strb_o  out  BW/8  byte strobes.
- nz_addr_o  out  32  byte address of the word.
- nz_valid_o  out  1  word pending.
- nz_ready_i  in  1  word consumed.
- nnz_o  out  32  nonzeros encoded so far in the current job.
- done_o  out  1  one-cycle pulse when the job is complete.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: takes start_i and latches the parameters. Goes to DONE if rows_i==0 or row_len_i==0, otherwise to RUN.
  - RUN: accepts elements.
  - DRAIN: emits the final partial nonzero word.
  - DONE: asserts done_o for one cycle, then returns to IDLE.
- start_i outside IDLE is ignored.
- Nonzero test: data_i != 0, compared bitwise. All-zero patterns are zero; no float semantics.
- Each accepted element sets bitmap bit col[log2(META_CHUNK_SIZE)-1:0] to the nonzero flag.
- Each nonzero element is written into pack lane lane_cnt, after which lane_cnt is incremented and nnz is incremented.
- Chunk emit happens when bit index META_CHUNK_SIZE-1 is written or at end of row.
  - Unused high bits of the chunk are 0. Each row therefore starts on a new chunk; padding is per row.
  - meta_addr = meta_base + chunk_idx*(META_CHUNK_SIZE/8). chunk_idx increments per emitted chunk.
- Word emit happens when lane_cnt reaches ELEMS.
  - nz_strb is all ones.
  - nz_addr = nz_base + word_idx*(BW/8).
  - Nonzeros are packed contiguously across rows.
- End of job is the last element of the last row.
  - If lane_cnt>0, go to DRAIN. DRAIN emits the partial word with unused lanes 0 and strobe bits set only for the filled lanes.
  - Otherwise go to DONE.
- Widths and wrap:
  - col and row counters are 16 bits.
  - chunk_idx, word_idx, nnz and the addresses are 32 bits and wrap modulo 2^32.
  - nnz_o holds its value after DONE until the next start.

## Timing
- Reset values: ready_o=0, all valid outputs 0, done_o=0, nnz_o=0, meta_o/nz_o/strb/addr outputs all 0. Reset returns the FSM to IDLE.
- Reset mid-job drops any pending output at that clock edge with no further writes; nothing is retained.
- ready_o = (state==RUN) && !meta_valid_o && !nz_valid_o.
- Outputs are registered. An element accepted at edge T that completes a chunk or word raises the corresponding valid at T+1.
- A single element may complete both a chunk and a word. Both valids then rise together and each clears independently on its own handshake.
- valid/data/addr/strb stay stable while valid && !ready.
- Peak rate: 1 element per cycle while no emit is pending. Each emit costs at least 1 stall cycle.
- DRAIN asserts nz_valid_o on the cycle after entry. DONE is entered on the cycle after the handshake.
- done_o is asserted the cycle after the final emit handshake, or at start+1 for an empty job.

## Structure
- accelerator_package gains:
  - the enc_state_e enum (IDLE, RUN, DRAIN, DONE);
  - an enc_param_t struct (rows, row_len, meta_base, nz_base);
  - the localparams ELEMS and META_CHUNK_BYTES.
- Sub-module nz_word_packer: owns the lane buffer, lane_cnt, strobe generation and word_idx/address. Interface is push + flush in, word valid/ready out.
- The top level holds the FSM, the row/col counters and the bitmap register.

## Test plan
1. Reset then idle: hold rst_i high 2 cycles, then low. Required: ready_o=0, all valids 0, done_o=0, nnz_o=0, and no activity without start_i.
2. One row, row_len=8, data 0,5,0,0,7,9,0,3 (BW=128, DATA_SIZE=32, META=32).
   - Bitmap: meta_o=0x000000B2 at meta_base.
   - Nonzero word: lanes 5,7,9,3, strb 0xFFFF at nz_base.
   - Both valids rise together after the 8th element.
   - done_o pulses; nnz_o=4.
3. One row, row_len=40, all elements nonzero.
   - Chunks: 0xFFFFFFFF at meta_base, 0x000000FF at meta_base+4.
   - 10 full words at nz_base+0x00 through nz_base+0x90.
   - nnz_o=40.
4. Two rows, row_len=3, data 1,0,2 / 0,0,3.
   - Chunks: 0x5 at meta_base, 0x4 at meta_base+4.
   - DRAIN word: lanes 1,2,3,0, strb 0x0FFF at nz_base.
   - nnz_o=3.
5. Backpressure: hold meta_ready_i low for 5 cycles with a chunk pending.
   - ready_o=0 and meta_o/addr stable throughout; no input is consumed.
   - An nz word pending at the same time completes independently on nz_ready_i.
6. Boundary cases:
   - start with rows_i=0: done_o at start+1, no valids.
   - rst_i asserted mid-row: all valids 0 next cycle and FSM in IDLE.
   - A following job restarts at meta_base/nz_base with nnz_o=0.
